alu_op_sequencer: RTL and testbench

//  Command-side initiator for the 4-bit ALU: accepts one ALU command per valid/ready handshake,

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_4bit.sv | 53 +++++
 rtl/alu_regfile.sv | 39 +++
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------
// alu_pkg - shared opcode, flag and width definitions for the ALU
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOTA = 3'b101,
    ALU_SHL  = 3'b110,
    ALU_SHR  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } alu_flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_4bit.sv
// ---------------------------------------------------------------
// alu_4bit - combinational 4-bit ALU with carry/overflow/zero flags
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module alu_4bit
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       carry,
  output logic       overflow,
  output logic       zero
);

  logic [4:0] sum;

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    sum      = '0;
    case (alu_op_e'(op))
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = sum[3:0];
        carry    = sum[4];
        overflow = (a[3] == b[3]) && (result[3] != a[3]);
      end
      // Subtract as a + ~b + 1 so carry-out means "no borrow".
      ALU_SUB: begin
        sum      = {1'b0, a} + {1'b0, ~b} + 5'd1;
        result   = sum[3:0];
        carry    = sum[4];
        overflow = (a[3] != b[3]) && (result[3] != a[3]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOTA: result = ~a;
      ALU_SHL:  result = {a[2:0], 1'b0};
      ALU_SHR:  result = {1'b0, a[3:1]};
      default:  result = '0;
    endcase
    zero = (result == 4'd0);
  end

endmodule

`default_nettype wire

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------
// alu_regfile - NREGS x DATA_W register file, 2 async reads, 1 sync write
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module alu_regfile #(
  parameter int NREGS  = 4,
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_a,
  output logic [DATA_W-1:0]        rdata_b,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------
// alu_op_sequencer - command/response sequencer driving a 4-bit ALU
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int NREGS  = 4,
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [$clog2(NREGS)-1:0] cmd_src_a,
  input  logic [$clog2(NREGS)-1:0] cmd_src_b,
  input  logic [$clog2(NREGS)-1:0] cmd_dst,
  input  logic                     cmd_imm_en,
  input  logic [DATA_W-1:0]        cmd_imm,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [2:0]               alu_op,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_overflow,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_result,
  output logic [2:0]               rsp_flags
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state;
  alu_op_e           cap_op;
  logic [RW-1:0]     cap_src_a;
  logic [RW-1:0]     cap_src_b;
  logic [RW-1:0]     cap_dst;
  logic              cap_imm_en;
  logic [DATA_W-1:0] cap_imm;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  alu_regfile #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (cap_src_a),
    .raddr_b (cap_src_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .we      (state == S_EXEC),
    .waddr   (cap_dst),
    .wdata   (alu_result)
  );

  // Operands track the captured command continuously; the write-back edge sees old values.
  assign alu_a  = rd_a;
  assign alu_b  = cap_imm_en ? cap_imm : rd_b;
  assign alu_op = cap_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cap_op     <= ALU_ADD;
      cap_src_a  <= '0;
      cap_src_b  <= '0;
      cap_dst    <= '0;
      cap_imm_en <= 1'b0;
      cap_imm    <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cap_op     <= alu_op_e'(cmd_op);
            cap_src_a  <= cmd_src_a;
            cap_src_b  <= cmd_src_b;
            cap_dst    <= cmd_dst;
            cap_imm_en <= cmd_imm_en;
            cap_imm    <= cmd_imm;
            cmd_ready  <= 1'b0;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags_t'{carry: alu_carry, overflow: alu_overflow, zero: alu_zero};
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------
// tb_alu_op_sequencer - randomized + directed bench with a behavioural model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_src_a = '0;
  logic [1:0] cmd_src_b = '0;
  logic [1:0] cmd_dst = '0;
  logic       cmd_imm_en = 1'b0;
  logic [3:0] cmd_imm = '0;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_carry, alu_overflow, alu_zero;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic [2:0] rsp_flags;

  int total = 0;
  int bad   = 0;
  int mdl_rf [4];

  always #5 clk = ~clk;

  alu_op_sequencer #(.NREGS(4), .DATA_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_src_a    (cmd_src_a),
    .cmd_src_b    (cmd_src_b),
    .cmd_dst      (cmd_dst),
    .cmd_imm_en   (cmd_imm_en),
    .cmd_imm      (cmd_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags)
  );

  alu_4bit u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  // Reference ALU: returns {result[3:0], carry, overflow, zero} from integer arithmetic.
  function automatic logic [6:0] model(input logic [2:0] op, input int a, input int b);
    int r, sa, sb, sr;
    bit c, v;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    c = 0; v = 0; r = 0;
    case (op)
      3'd0: begin r = a + b; c = (r > 15); sr = sa + sb; v = (sr > 7) || (sr < -8); end
      3'd1: begin r = a - b; c = (a >= b); sr = sa - sb; v = (sr > 7) || (sr < -8); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 15 - a;
      3'd6: r = a * 2;
      default: r = a / 2;
    endcase
    r = r & 15;
    return {r[3:0], c, v, (r == 0)};
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ie, input logic [3:0] imm, input int hold,
                         output logic [3:0] res, output logic [2:0] flg,
                         output logic [3:0] ea, output logic [3:0] eb, output logic [2:0] eop,
                         output int lat, output logic [3:0] xres, output logic [2:0] xflg,
                         output logic [3:0] xa, output logic [3:0] xb);
    logic [6:0] m;
    int n;
    xa = 4'(mdl_rf[sa]);
    xb = ie ? imm : 4'(mdl_rf[sb]);
    m = model(op, int'(xa), int'(xb));
    xres = m[6:3];
    xflg = m[2:0];
    res = 'x; flg = 'x; ea = 'x; eb = 'x; eop = 'x; lat = -1;
    cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb; cmd_imm_en = ie; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ea = alu_a; eb = alu_b; eop = alu_op;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!rsp_valid) return;
    lat = n;
    res = rsp_result;
    flg = rsp_flags;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    mdl_rf[dst] = int'(xres);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 4; i++) mdl_rf[i] = 0;
    total++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_flags} !== {1'b1, 1'b0, 4'd0, 3'd0}) begin
      bad++;
      $display("FAIL reset_rsp: got ready=%b valid=%b res=%h flags=%b, want 1 0 0 000",
               cmd_ready, rsp_valid, rsp_result, rsp_flags);
    end
    total++;
    if ({alu_a, alu_b, alu_op} !== 11'd0) begin
      bad++;
      $display("FAIL reset_alu: got a=%h b=%h op=%h, want 0 0 0", alu_a, alu_b, alu_op);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b valid=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_directed();
    logic [3:0] res, ea, eb, xres, xa, xb;
    logic [2:0] flg, eop, xflg;
    int lat;
    // {op, dst, src_a, src_b, imm_en, imm, expected result, expected flags}
    logic [2:0] ops  [5] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd6};
    logic [1:0] dsts [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [1:0] srcs [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    logic [3:0] imms [5] = '{4'd5, 4'd2, 4'd9, 4'd8, 4'd0};
    logic [3:0] eres [5] = '{4'd5, 4'd7, 4'd0, 4'hF, 4'hE};
    logic [2:0] eflg [5] = '{3'b000, 3'b000, 3'b101, 3'b010, 3'b000};
    for (int i = 0; i < 5; i++) begin
      run_cmd(ops[i], dsts[i], srcs[i], srcs[i], (i != 4), imms[i], 0,
              res, flg, ea, eb, eop, lat, xres, xflg, xa, xb);
      total++;
      if (lat !== 2) begin
        bad++;
        $display("FAIL dir%0d_latency: got %0d cycles, want 2", i, lat);
      end
      total++;
      if (res !== eres[i] || flg !== eflg[i]) begin
        bad++;
        $display("FAIL dir%0d_result: got res=%h flags=%b, want res=%h flags=%b",
                 i, res, flg, eres[i], eflg[i]);
      end
    end
    run_cmd(3'd0, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0, 0, res, flg, ea, eb, eop, lat, xres, xflg, xa, xb);
    total++;
    if (res !== 4'hE || ea !== 4'hE) begin
      bad++;
      $display("FAIL dir_readback: got res=%h alu_a=%h, want E E", res, ea);
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] m1, m2;
    int a2;
    m1 = model(3'd4, mdl_rf[1], mdl_rf[0]);
    cmd_op = 3'd4; cmd_dst = 2'd2; cmd_src_a = 2'd1; cmd_src_b = 2'd0; cmd_imm_en = 1'b0;
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_idle_ready: got %b, want 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_op = 3'd3; cmd_dst = 2'd3; cmd_src_a = 2'd2; cmd_src_b = 2'd1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_result !== m1[6:3] || rsp_flags !== m1[2:0]) begin
        bad++;
        $display("FAIL bp_hold%0d: got valid=%b ready=%b res=%h flags=%b, want 1 0 %h %b",
                 i, rsp_valid, cmd_ready, rsp_result, rsp_flags, m1[6:3], m1[2:0]);
      end
      @(posedge clk); #1;
    end
    mdl_rf[2] = int'(m1[6:3]);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got valid=%b ready=%b, want 0 1", rsp_valid, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    a2 = mdl_rf[2];
    m2 = model(3'd3, a2, mdl_rf[1]);
    total++;
    if (cmd_ready !== 1'b0 || alu_op !== 3'd3 || alu_a !== 4'(a2)) begin
      bad++;
      $display("FAIL bp_second_accept: got ready=%b op=%h a=%h, want 0 3 %h", cmd_ready, alu_op, alu_a, 4'(a2));
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_result !== m2[6:3] || rsp_flags !== m2[2:0]) begin
      bad++;
      $display("FAIL bp_second_rsp: got valid=%b res=%h flags=%b, want 1 %h %b",
               rsp_valid, rsp_result, rsp_flags, m2[6:3], m2[2:0]);
    end
    mdl_rf[3] = int'(m2[6:3]);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] res, ea, eb, xres, xa, xb;
    logic [2:0] flg, eop, xflg;
    int lat;
    run_cmd(3'd2, 2'd1, 2'd0, 2'd0, 1'b1, 4'd0, 0, res, flg, ea, eb, eop, lat, xres, xflg, xa, xb);
    run_cmd(3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 4'd7, 0, res, flg, ea, eb, eop, lat, xres, xflg, xa, xb);
    cmd_op = 3'd0; cmd_dst = 2'd1; cmd_src_a = 2'd1; cmd_imm_en = 1'b1; cmd_imm = 4'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) mdl_rf[i] = 0;
    total++;
    if ({rsp_valid, cmd_ready, rsp_result, rsp_flags, alu_a, alu_b, alu_op} !== {1'b0, 1'b1, 18'd0}) begin
      bad++;
      $display("FAIL arst_outputs: got valid=%b ready=%b res=%h flags=%b a=%h b=%h op=%h, want 0 1 all-zero",
               rsp_valid, cmd_ready, rsp_result, rsp_flags, alu_a, alu_b, alu_op);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL arst_post_release: got ready=%b valid=%b, want 1 0", cmd_ready, rsp_valid);
    end
    run_cmd(3'd0, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0, 0, res, flg, ea, eb, eop, lat, xres, xflg, xa, xb);
    total++;
    if (res !== 4'd0 || flg !== 3'b001) begin
      bad++;
      $display("FAIL arst_rf_cleared: got res=%h flags=%b, want 0 001", res, flg);
    end
  endtask

  task automatic test_random();
    logic [3:0] res, ea, eb, xres, xa, xb;
    logic [2:0] flg, eop, xflg, op;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      run_cmd(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
              res, flg, ea, eb, eop, lat, xres, xflg, xa, xb);
      total++;
      if (lat !== 2) begin
        bad++;
        $display("FAIL rnd%0d_latency: got %0d, want 2", i, lat);
      end
      total++;
      if (ea !== xa || eb !== xb || eop !== op) begin
        bad++;
        $display("FAIL rnd%0d_operands: got a=%h b=%h op=%h, want a=%h b=%h op=%h",
                 i, ea, eb, eop, xa, xb, op);
      end
      total++;
      if (res !== xres || flg !== xflg) begin
        bad++;
        $display("FAIL rnd%0d_result: op=%h got res=%h flags=%b, want res=%h flags=%b",
                 i, op, res, flg, xres, xflg);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
